// File: rtl/sd_audio_stream_ctrl.sv
// sd_audio_stream_ctrl: sequences 512-byte SD block reads into the audio
// sample FIFO so the PWM player never starves. One block is read at a time,
// only when the FIFO has room for a whole block.
// Optional build macro: SD_STREAM_LOOP_EN. When defined, the stream loops
// back to the base address after the last block until stopped.
module sd_audio_stream_ctrl #(
    parameter int BLOCK_BYTES = 512,
    parameter int FIFO_DEPTH  = 2048,
    parameter int CNT_W       = 11
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic [31:0]      base_addr,
    input  logic [23:0]      num_blocks,
    input  logic             sd_ready,
    input  logic             sd_byte_available,
    input  logic [7:0]       sd_dout,
    output logic             sd_rd,
    output logic [31:0]      sd_address,
    input  logic [CNT_W-1:0] fifo_count,
    input  logic             fifo_full,
    output logic             fifo_wr_en,
    output logic [7:0]       fifo_din,
    output logic             busy,
    output logic             done,
    output logic             err_overflow,
    output logic [23:0]      blocks_done,
    output logic [2:0]       state
);
    localparam int BC_W = $clog2(BLOCK_BYTES + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ROOM   = 3'd1,
        ISSUE  = 3'd2,
        ACK    = 3'd3,
        STREAM = 3'd4,
        NEXT   = 3'd5,
        DONE   = 3'd6
    } state_t;

    state_t          cur_state;
    state_t          next_state;
    logic [23:0]     num_latched;
    logic [BC_W-1:0] byte_cnt;
    logic            byte_avail_q;
    logic            stop_pend;
    logic            byte_edge;
    logic            room_ok;
    logic            stop_req;
    logic            last_block;
    logic [31:0]     room_avail;
`ifdef SD_STREAM_LOOP_EN
    logic [31:0]     base_latched;
`endif

    // A new SD byte is announced by a rising edge on the level-type strobe
    assign byte_edge  = sd_byte_available & ~byte_avail_q;
    assign room_avail = 32'(FIFO_DEPTH) - 32'(fifo_count);
    assign room_ok    = room_avail >= 32'(BLOCK_BYTES);
    assign stop_req   = stop_pend | stop;
    assign last_block = (blocks_done + 24'd1) == num_latched;
    assign busy       = (cur_state != IDLE);
    assign state      = cur_state;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= next_state;
        end
    end

    // Next-state logic; a started SD read always runs to the end of its block
    always_comb begin
        next_state = cur_state;
        case (cur_state)
            IDLE: begin
                if (start) begin
                    next_state = (num_blocks == 24'd0) ? DONE : ROOM;
                end
            end
            ROOM: begin
                if (stop_req) begin
                    next_state = DONE;
                end else if (room_ok && sd_ready) begin
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                if (sd_rd && !sd_ready) begin
                    next_state = STREAM;
                end
            end
            ACK: begin
                next_state = STREAM;
            end
            STREAM: begin
                if ((byte_cnt == BC_W'(BLOCK_BYTES)) && sd_ready) begin
                    next_state = NEXT;
                end
            end
            NEXT: begin
`ifdef SD_STREAM_LOOP_EN
                next_state = stop_req ? DONE : ROOM;
`else
                next_state = (last_block || stop_req) ? DONE : ROOM;
`endif
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Read request: raised the cycle after entering ISSUE, dropped once the controller goes busy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sd_rd <= 1'b0;
        end else begin
            sd_rd <= (cur_state == ISSUE) && (next_state == ISSUE);
        end
    end

    // Block address, block count and per-block byte counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sd_address   <= 32'd0;
            blocks_done  <= 24'd0;
            num_latched  <= 24'd0;
            byte_cnt     <= '0;
`ifdef SD_STREAM_LOOP_EN
            base_latched <= 32'd0;
`endif
        end else begin
            case (cur_state)
                IDLE: begin
                    if (start) begin
                        sd_address   <= base_addr;
                        blocks_done  <= 24'd0;
                        num_latched  <= num_blocks;
                        byte_cnt     <= '0;
`ifdef SD_STREAM_LOOP_EN
                        base_latched <= base_addr;
`endif
                    end
                end
                STREAM: begin
                    if (byte_edge) begin
                        byte_cnt <= byte_cnt + BC_W'(1);
                    end
                end
                NEXT: begin
                    byte_cnt <= '0;
`ifdef SD_STREAM_LOOP_EN
                    if (last_block && !stop_req) begin
                        sd_address  <= base_latched;
                        blocks_done <= 24'd0;
                    end else begin
                        sd_address  <= sd_address + 32'(BLOCK_BYTES);
                        blocks_done <= blocks_done + 24'd1;
                    end
`else
                    sd_address  <= sd_address + 32'(BLOCK_BYTES);
                    blocks_done <= blocks_done + 24'd1;
`endif
                end
                default: begin
                end
            endcase
        end
    end

    // Byte capture: one FIFO write per strobe edge, suppressed while the FIFO is full
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_avail_q <= 1'b0;
            fifo_wr_en   <= 1'b0;
            fifo_din     <= 8'd0;
        end else begin
            byte_avail_q <= sd_byte_available;
            fifo_wr_en   <= 1'b0;
            if ((cur_state == STREAM) && byte_edge) begin
                fifo_din   <= sd_dout;
                fifo_wr_en <= ~fifo_full;
            end
        end
    end

    // Control flags: sticky overflow, pending stop and the completion pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_overflow <= 1'b0;
            stop_pend    <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= (cur_state == DONE);
            if ((cur_state == IDLE) || (cur_state == DONE)) begin
                stop_pend <= 1'b0;
            end else if (stop) begin
                stop_pend <= 1'b1;
            end
            if ((cur_state == IDLE) && start) begin
                err_overflow <= 1'b0;
            end else if ((cur_state == STREAM) && byte_edge && fifo_full) begin
                err_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sd_audio_stream_ctrl.sv
// Testbench for sd_audio_stream_ctrl: behavioural SD card model, expected
// byte/address queues, per-cycle compare process and directed scenarios.
`timescale 1ns/1ps
module tb_sd_audio_stream_ctrl;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        stop;
    logic [31:0] base_addr;
    logic [23:0] num_blocks;
    logic        sd_ready;
    logic        sd_byte_available;
    logic [7:0]  sd_dout;
    logic        sd_rd;
    logic [31:0] sd_address;
    logic [10:0] fifo_count;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [7:0]  fifo_din;
    logic        busy;
    logic        done;
    logic        err_overflow;
    logic [23:0] blocks_done;
    logic [2:0]  state;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0]  exp_q[$];
    logic [31:0] addr_q[$];
    int          wr_count   = 0;
    int          rd_rises   = 0;
    int          done_count = 0;
    logic        rd_q       = 1'b0;
    logic [7:0]  first_din  = 8'd0;
    logic [7:0]  last_din   = 8'd0;
    bit          first_seen = 1'b0;
    int          byte_idx   = -1;
    bit          sd_kill    = 1'b0;
    int          full_lo    = -1;
    int          full_hi    = -1;

    int wr0, rd0, done0, lat;

    sd_audio_stream_ctrl dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start),
        .stop              (stop),
        .base_addr         (base_addr),
        .num_blocks        (num_blocks),
        .sd_ready          (sd_ready),
        .sd_byte_available (sd_byte_available),
        .sd_dout           (sd_dout),
        .sd_rd             (sd_rd),
        .sd_address        (sd_address),
        .fifo_count        (fifo_count),
        .fifo_full         (fifo_full),
        .fifo_wr_en        (fifo_wr_en),
        .fifo_din          (fifo_din),
        .busy              (busy),
        .done              (done),
        .err_overflow      (err_overflow),
        .blocks_done       (blocks_done),
        .state             (state)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Data pattern delivered by the SD model for byte i of the block at address a
    function automatic logic [7:0] sd_byte(input logic [31:0] a, input int i);
        logic [7:0] lo;
        logic [7:0] hi;
        logic [7:0] blk;
        lo  = 8'(i);
        hi  = 8'(i >> 8);
        blk = 8'(a >> 9);
        return lo + hi * 8'h80 + blk * 8'h11;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic failEvent(input string name, input string detail);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: %s", name, detail);
    endtask

    task automatic applyStimulus(input logic [31:0] base, input logic [23:0] num, input logic with_stop);
        @(negedge clk);
        base_addr  = base;
        num_blocks = num;
        start      = 1'b1;
        stop       = with_stop;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        int k;
        k = 0;
        while (!done && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!done) failEvent("done_timeout", "got no done pulse, expected one");
        repeat (4) @(negedge clk);
    endtask

    task automatic waitByte(input int n);
        int k;
        k = 0;
        while (byte_idx != n && k < 4000) begin
            @(posedge clk);
            k++;
        end
        if (byte_idx != n) failEvent("byte_timeout", "got no SD byte at the requested index, expected one");
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".sd_rd"},        64'(sd_rd),        64'd0);
        checkOutput({tag, ".sd_address"},   64'(sd_address),   64'd0);
        checkOutput({tag, ".fifo_wr_en"},   64'(fifo_wr_en),   64'd0);
        checkOutput({tag, ".fifo_din"},     64'(fifo_din),     64'd0);
        checkOutput({tag, ".busy"},         64'(busy),         64'd0);
        checkOutput({tag, ".done"},         64'(done),         64'd0);
        checkOutput({tag, ".err_overflow"}, 64'(err_overflow), 64'd0);
        checkOutput({tag, ".blocks_done"},  64'(blocks_done),  64'd0);
        checkOutput({tag, ".state"},        64'(state),        64'd0);
    endtask

    // SD card model: accepts a read, delivers 512 paced bytes, then returns to ready
    initial begin : sd_model
        logic [31:0] cur_addr;
        sd_ready          = 1'b1;
        sd_byte_available = 1'b0;
        sd_dout           = 8'd0;
        fifo_full         = 1'b0;
        forever begin
            @(negedge clk);
            if (sd_rd && sd_ready && reset_n) begin
                cur_addr = sd_address;
                sd_ready = 1'b0;
                byte_idx = -1;
                repeat (2) @(negedge clk);
                for (int i = 0; i < 512 && !sd_kill; i++) begin
                    byte_idx          = i;
                    sd_dout           = sd_byte(cur_addr, i);
                    fifo_full         = (i >= full_lo) && (i <= full_hi);
                    if (!fifo_full) exp_q.push_back(sd_dout);
                    sd_byte_available = 1'b1;
                    @(negedge clk);
                    fifo_full         = 1'b0;
                    sd_byte_available = 1'b0;
                    @(negedge clk);
                end
                repeat (2) @(negedge clk);
                sd_ready = 1'b1;
            end
        end
    end

    // Compare process: read addresses, written bytes and busy on every cycle out of reset
    always @(posedge clk) begin
        #1;
        if (reset_n) begin
            if (sd_rd && !rd_q) begin
                rd_rises++;
                if (addr_q.size() == 0) failEvent("sd_rd", "got a read request, expected none");
                else checkOutput("sd_address", 64'(sd_address), 64'(addr_q.pop_front()));
            end
            if (fifo_wr_en) begin
                wr_count++;
                if (!first_seen) begin
                    first_din  = fifo_din;
                    first_seen = 1'b1;
                end
                last_din = fifo_din;
                if (exp_q.size() == 0) failEvent("fifo_wr_en", "got a FIFO write, expected none");
                else checkOutput("fifo_din", 64'(fifo_din), 64'(exp_q.pop_front()));
            end
            if (done) done_count++;
            checkOutput("busy", 64'(busy), 64'(state != 3'd0));
        end
        rd_q = sd_rd;
    end

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios
    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        base_addr  = 32'd0;
        num_blocks = 24'd0;
        fifo_count = 11'd0;
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] two blocks from 0x400");
        addr_q.push_back(32'h400);
        addr_q.push_back(32'h600);
        wr0 = wr_count; rd0 = rd_rises; done0 = done_count;
        applyStimulus(32'h400, 24'd2, 1'b0);
        lat = 1;
        while (!sd_rd && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("start_to_rd_latency", 64'(lat), 64'd3);
        waitDone(6000);
        checkOutput("t1.writes",      64'(wr_count - wr0),     64'd1024);
        checkOutput("t1.blocks_done", 64'(blocks_done),        64'd2);
        checkOutput("t1.done_pulses", 64'(done_count - done0), 64'd1);
        checkOutput("t1.rd_count",    64'(rd_rises - rd0),     64'd2);
        checkOutput("t1.first_byte",  64'(first_din),          64'h22);
        checkOutput("t1.last_byte",   64'(last_din),           64'hB2);
        checkOutput("t1.exp_left",    64'(exp_q.size()),       64'd0);
        checkOutput("t1.state",       64'(state),              64'd0);

        $display("[TB] FIFO room gating");
        fifo_count = 11'd1600;
        addr_q.push_back(32'h0);
        wr0 = wr_count; rd0 = rd_rises;
        applyStimulus(32'h0, 24'd1, 1'b0);
        repeat (20) @(negedge clk);
        checkOutput("t2.state_room", 64'(state),          64'd1);
        checkOutput("t2.rd_held",    64'(sd_rd),          64'd0);
        checkOutput("t2.no_rd",      64'(rd_rises - rd0), 64'd0);
        fifo_count = 11'd1536;
        lat = 0;
        while (!sd_rd && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("t2.room_to_rd", 64'(lat), 64'd2);
        @(negedge clk);
        fifo_count = 11'd0;
        waitDone(4000);
        checkOutput("t2.writes",    64'(wr_count - wr0), 64'd512);
        checkOutput("t2.last_byte", 64'(last_din),       64'h7F);

        $display("[TB] stop during block 0 of 5");
        addr_q.push_back(32'h2000);
        wr0 = wr_count; rd0 = rd_rises; done0 = done_count;
        applyStimulus(32'h2000, 24'd5, 1'b0);
        waitByte(100);
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        waitDone(4000);
        repeat (20) @(negedge clk);
        checkOutput("t3.writes",      64'(wr_count - wr0),     64'd512);
        checkOutput("t3.blocks_done", 64'(blocks_done),        64'd1);
        checkOutput("t3.done_pulses", 64'(done_count - done0), 64'd1);
        checkOutput("t3.rd_count",    64'(rd_rises - rd0),     64'd1);

        $display("[TB] FIFO full during bytes 10-12");
        full_lo = 10;
        full_hi = 12;
        addr_q.push_back(32'h800);
        wr0 = wr_count;
        applyStimulus(32'h800, 24'd1, 1'b0);
        waitDone(4000);
        full_lo = -1;
        full_hi = -1;
        checkOutput("t4.writes",   64'(wr_count - wr0), 64'd509);
        checkOutput("t4.overflow", 64'(err_overflow),   64'd1);
        repeat (10) @(negedge clk);
        checkOutput("t4.overflow_sticky", 64'(err_overflow), 64'd1);

        $display("[TB] zero blocks");
        rd0 = rd_rises; done0 = done_count;
        applyStimulus(32'h800, 24'd0, 1'b0);
        lat = 1;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("t6.start_to_done", 64'(lat),          64'd2);
        checkOutput("t6.overflow_clr",  64'(err_overflow), 64'd0);
        repeat (4) @(negedge clk);
        checkOutput("t6.rd_count",    64'(rd_rises - rd0),     64'd0);
        checkOutput("t6.done_pulses", 64'(done_count - done0), 64'd1);
        checkOutput("t6.blocks_done", 64'(blocks_done),        64'd0);

        $display("[TB] reset at byte 300");
        addr_q.push_back(32'h1000);
        applyStimulus(32'h1000, 24'd3, 1'b0);
        waitByte(300);
        #2;
        reset_n = 1'b0;
        sd_kill = 1'b1;
        #1;
        checkAllZero("t5.async_reset");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        lat = 0;
        while (!sd_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        sd_kill = 1'b0;
        exp_q.delete();
        addr_q.delete();
        wr0 = wr_count;
        repeat (30) @(negedge clk);
        checkOutput("t5.no_writes", 64'(wr_count - wr0), 64'd0);
        checkOutput("t5.state",     64'(state),          64'd0);

`ifdef SD_STREAM_LOOP_EN
        $display("[TB] looping playback of one block");
        addr_q.push_back(32'h400);
        addr_q.push_back(32'h400);
        addr_q.push_back(32'h400);
        rd0 = rd_rises;
        applyStimulus(32'h400, 24'd1, 1'b0);
        lat = 0;
        while ((rd_rises - rd0) < 3 && lat < 6000) begin
            @(negedge clk);
            lat++;
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        waitDone(4000);
        checkOutput("loop.rd_count", 64'(rd_rises - rd0), 64'd3);
        checkOutput("loop.addr_left", 64'(addr_q.size()), 64'd0);
`endif

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
